// File: rtl/gpi_debounce_pkg.sv
// Shared defaults, types and helpers for the gpi_debounce input-conditioning block.
package gpi_debounce_pkg;

  localparam int GpiDbWidthDefault  = 6;
  localparam int GpiDbCyclesDefault = 50000;
  localparam int GpiDbSyncDefault   = 2;

  // One-cycle edge pulses produced by a single debounced channel.
  typedef struct packed {
    logic rise;
    logic fall;
  } gpi_db_pulse_t;

  // Counter width able to hold 0 .. cycles (the counter itself stops at cycles-1).
  function automatic int gpi_db_cnt_width(input int cycles);
    return $clog2(cycles + 1);
  endfunction

endpackage

// File: rtl/gpi_debounce_chan.sv
// One debounced input channel: synchroniser chain, stability counter,
// stable-value flop and registered rise/fall pulses.
module gpi_debounce_chan
  import gpi_debounce_pkg::*;
#(
  parameter int   SyncStages     = GpiDbSyncDefault,
  parameter int   DebounceCycles = GpiDbCyclesDefault,
  parameter logic RstVal         = 1'b0,
  parameter int   CntWidth       = gpi_db_cnt_width(DebounceCycles)
) (
  input  logic          clk,
  input  logic          srst,
  input  logic          raw,
  output logic          stable,
  output gpi_db_pulse_t pulse
);

  localparam logic [CntWidth-1:0] CntLast = CntWidth'(DebounceCycles - 1);

  logic [SyncStages-1:0] sync_reg;
  logic [CntWidth-1:0]   cnt_reg;
  logic                  stable_reg;
  logic                  rise_reg;
  logic                  fall_reg;
  logic                  s;

  assign s = sync_reg[SyncStages-1];

  // Plain shift chain: nothing but flops between the pin and s.
  always_ff @(posedge clk) begin
    if (srst) begin
      sync_reg <= {SyncStages{RstVal}};
    end else begin
      sync_reg <= {sync_reg[SyncStages-2:0], raw};
    end
  end

  // Accept s once it has differed from the stable value for DebounceCycles
  // consecutive cycles; any return to the stable value restarts the count.
  always_ff @(posedge clk) begin
    if (srst) begin
      cnt_reg    <= '0;
      stable_reg <= RstVal;
      rise_reg   <= 1'b0;
      fall_reg   <= 1'b0;
    end else begin
      rise_reg <= 1'b0;
      fall_reg <= 1'b0;
      if (s == stable_reg) begin
        cnt_reg <= '0;
      end else if (cnt_reg == CntLast) begin
        cnt_reg    <= '0;
        stable_reg <= s;
        rise_reg   <= s;
        fall_reg   <= ~s;
      end else begin
        cnt_reg <= cnt_reg + 1'b1;
      end
    end
  end

  assign stable     = stable_reg;
  assign pulse.rise = rise_reg;
  assign pulse.fall = fall_reg;

endmodule

// File: rtl/gpi_debounce.sv
// Multi-channel conditioning block for raw board switches/buttons feeding the
// demo-system GPI. Optional sticky edge status and interrupt are built only
// when the macro GPI_DEBOUNCE_IRQ_EN is defined; otherwise status_o and irq_o
// are tied low and the enable/clear inputs are ignored.
module gpi_debounce
  import gpi_debounce_pkg::*;
#(
  parameter int               Width          = GpiDbWidthDefault,
  parameter int               SyncStages     = GpiDbSyncDefault,
  parameter int               DebounceCycles = GpiDbCyclesDefault,
  parameter logic [Width-1:0] RstVal         = '0,
  parameter int               CntWidth       = gpi_db_cnt_width(DebounceCycles)
) (
  input  logic             clk_sys_i,
  input  logic             rst_sys_i,
  input  logic [Width-1:0] gp_raw_i,
  output logic [Width-1:0] gp_o,
  output logic [Width-1:0] rise_o,
  output logic [Width-1:0] fall_o,
  input  logic [Width-1:0] rise_en_i,
  input  logic [Width-1:0] fall_en_i,
  input  logic [Width-1:0] clr_i,
  output logic [Width-1:0] status_o,
  output logic             irq_o
);

  gpi_db_pulse_t pulse [Width];

  for (genvar gi = 0; gi < Width; gi++) begin : g_chan
    gpi_debounce_chan #(
      .SyncStages    (SyncStages),
      .DebounceCycles(DebounceCycles),
      .RstVal        (RstVal[gi]),
      .CntWidth      (CntWidth)
    ) u_chan (
      .clk   (clk_sys_i),
      .srst  (rst_sys_i),
      .raw   (gp_raw_i[gi]),
      .stable(gp_o[gi]),
      .pulse (pulse[gi])
    );
    assign rise_o[gi] = pulse[gi].rise;
    assign fall_o[gi] = pulse[gi].fall;
  end

`ifdef GPI_DEBOUNCE_IRQ_EN
  logic [Width-1:0] status_reg;
  logic [Width-1:0] status_next;
  logic             irq_reg;

  // Sticky status: a qualified edge pulse sets, write-1 clears, set wins.
  always_comb begin
    status_next = (status_reg & ~clr_i) | (rise_o & rise_en_i) | (fall_o & fall_en_i);
  end

  // Register status and derive irq from the next state so both move together.
  always_ff @(posedge clk_sys_i) begin
    if (rst_sys_i) begin
      status_reg <= '0;
      irq_reg    <= 1'b0;
    end else begin
      status_reg <= status_next;
      irq_reg    <= |status_next;
    end
  end

  assign status_o = status_reg;
  assign irq_o    = irq_reg;
`else
  logic unused_irq_inputs;
  assign unused_irq_inputs = ^{rise_en_i, fall_en_i, clr_i};

  assign status_o = '0;
  assign irq_o    = 1'b0;
`endif

endmodule
